// File: rtl/gumnut_inst_queue.sv
// Gumnut instruction fetch queue and instruction register.
// Issues sequential fetches over a strobe/acknowledge handshake, buffers up to DEPTH
// instructions with their addresses, and presents the head entry split into decode fields.
// Optional feature: define IR_BYPASS_EN to forward an acked instruction straight to the
// head outputs when the queue is empty.
module gumnut_inst_queue #(
    parameter int unsigned   DEPTH      = 2,
    parameter int unsigned   AW         = 12,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          fetch_stb_o,
    output logic [AW-1:0] fetch_adr_o,
    input  logic          ack_i,
    input  logic [17:0]   inst_i,
    input  logic          flush_i,
    input  logic [AW-1:0] flush_addr_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [AW-1:0] pc_o,
    output logic [6:0]    op_o,
    output logic [2:0]    func_o,
    output logic [2:0]    rd_o,
    output logic [2:0]    rs_o,
    output logic [2:0]    rs2_o,
    output logic [2:0]    count_o,
    output logic [7:0]    immed_o,
    output logic [7:0]    offset_o,
    output logic [7:0]    disp_o,
    output logic [11:0]   addr_o
);

    localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [17:0]     inst_mem_q [DEPTH];
    logic [AW-1:0]   pc_mem_q   [DEPTH];

    logic            push, pop_store, bypass;
    logic            head_valid;
    logic [17:0]     head_inst;
    logic [AW-1:0]   head_pc;

    // Select the head entry, or the in-flight ack when it is forwarded directly.
    always_comb begin
        head_valid = (count_q != '0);
        head_inst  = inst_mem_q[head_q];
        head_pc    = pc_mem_q[head_q];
        bypass     = 1'b0;
`ifdef IR_BYPASS_EN
        if ((state_q == StFetch) && ack_i && !flush_i && (count_q == '0)) begin
            bypass     = 1'b1;
            head_valid = 1'b1;
            head_inst  = inst_i;
            head_pc    = fetch_pc_q;
        end
`endif
    end

    // Fetch FSM, queue pointers and fetch address next-state.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        pop_store  = 1'b0;
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = flush_addr_i;
            // A request still waiting for its ack becomes stale and must be drained.
            if ((state_q != StIdle) && !ack_i) begin
                state_d = StDiscard;
            end else begin
                state_d = StFetch;
            end
        end else begin
            pop_store = (count_q != '0) && ready_i;
            // A bypassed instruction consumed this cycle never enters storage.
            push      = (state_q == StFetch) && ack_i && !(bypass && ready_i);
            count_d   = count_q + CntW'(push) - CntW'(pop_store);
            head_d    = head_q + PtrW'(pop_store);
            tail_d    = tail_q + PtrW'(push);
            if ((state_q == StFetch) && ack_i) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            unique case (state_q)
                StIdle, StFetch: begin
                    if ((state_q == StFetch) && !ack_i) begin
                        state_d = StFetch;
                    end else begin
                        state_d = (count_d < DepthCnt) ? StFetch : StIdle;
                    end
                end
                StDiscard: begin
                    if (ack_i) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // The presented address stays frozen while a stale request drains.
        adr_d = (state_d == StDiscard) ? adr_q : fetch_pc_d;
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_ADDR;
            adr_q      <= RESET_ADDR;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            adr_q      <= adr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem_q[tail_q] <= inst_i;
            pc_mem_q[tail_q]   <= fetch_pc_q;
        end
    end

    assign fetch_stb_o = (state_q != StIdle);
    assign fetch_adr_o = adr_q;
    assign valid_o     = head_valid;

    // Decode fields of the head instruction, zeroed when nothing is valid.
    always_comb begin
        pc_o     = '0;
        op_o     = '0;
        func_o   = '0;
        rd_o     = '0;
        rs_o     = '0;
        rs2_o    = '0;
        count_o  = '0;
        immed_o  = '0;
        offset_o = '0;
        disp_o   = '0;
        addr_o   = '0;
        if (head_valid) begin
            pc_o     = head_pc;
            op_o     = {3'b000, head_inst[17:14]};
            func_o   = head_inst[17] ? head_inst[2:0] : head_inst[16:14];
            rd_o     = head_inst[13:11];
            rs_o     = head_inst[10:8];
            rs2_o    = head_inst[7:5];
            count_o  = head_inst[7:5];
            immed_o  = head_inst[7:0];
            offset_o = head_inst[7:0];
            disp_o   = head_inst[7:0];
            addr_o   = head_inst[11:0];
        end
    end

endmodule

// File: tb/tb_gumnut_inst_queue.sv
// Self-checking bench for gumnut_inst_queue: directed scenarios with literal expectations
// plus a long randomized run compared every cycle against a queue-based reference model.
module tb_gumnut_inst_queue;

    localparam int unsigned   DEPTH      = 2;
    localparam int unsigned   AW         = 12;
    localparam logic [AW-1:0] RESET_ADDR = 12'h000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          fetch_stb_o;
    logic [AW-1:0] fetch_adr_o;
    logic          ack_i;
    logic [17:0]   inst_i;
    logic          flush_i;
    logic [AW-1:0] flush_addr_i;
    logic          valid_o;
    logic          ready_i;
    logic [AW-1:0] pc_o;
    logic [6:0]    op_o;
    logic [2:0]    func_o, rd_o, rs_o, rs2_o, count_o;
    logic [7:0]    immed_o, offset_o, disp_o;
    logic [11:0]   addr_o;

    int tests_run    = 0;
    int tests_failed = 0;

    gumnut_inst_queue #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fetch_stb_o  (fetch_stb_o),
        .fetch_adr_o  (fetch_adr_o),
        .ack_i        (ack_i),
        .inst_i       (inst_i),
        .flush_i      (flush_i),
        .flush_addr_i (flush_addr_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .pc_o         (pc_o),
        .op_o         (op_o),
        .func_o       (func_o),
        .rd_o         (rd_o),
        .rs_o         (rs_o),
        .rs2_o        (rs2_o),
        .count_o      (count_o),
        .immed_o      (immed_o),
        .offset_o     (offset_o),
        .disp_o       (disp_o),
        .addr_o       (addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {inst, pc} plus the request currently presented to memory.
    typedef struct packed {
        logic [17:0]   inst;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        mq[$];
    bit            m_req;
    bit            m_stale;
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_target;

    task automatic model_reset();
        mq.delete();
        m_req    = 1'b0;
        m_stale  = 1'b0;
        m_addr   = RESET_ADDR;
        m_target = RESET_ADDR;
    endtask

    task automatic compare_and_step();
        entry_t head;
        entry_t e;
        bit     exp_valid;
        bit     byp;
        bit     popped;
        byp       = 1'b0;
        exp_valid = (mq.size() != 0);
        head      = (mq.size() != 0) ? mq[0] : '0;
`ifdef IR_BYPASS_EN
        if (m_req && !m_stale && ack_i && !flush_i && (mq.size() == 0)) begin
            byp       = 1'b1;
            exp_valid = 1'b1;
            head.inst = inst_i;
            head.pc   = m_addr;
        end
`endif
        check("m_stb", 32'(fetch_stb_o), 32'(m_req));
        if (m_req) check("m_adr", 32'(fetch_adr_o), 32'(m_addr));
        check("m_valid", 32'(valid_o), 32'(exp_valid));
        if (!exp_valid) head = '0;
        check("m_pc", 32'(pc_o), 32'(head.pc));
        check("m_op", 32'(op_o), 32'({3'b000, head.inst[17:14]}));
        check("m_func", 32'(func_o),
              32'(head.inst[17] ? head.inst[2:0] : head.inst[16:14]));
        check("m_rd", 32'(rd_o), 32'(head.inst[13:11]));
        check("m_rs", 32'(rs_o), 32'(head.inst[10:8]));
        check("m_rs2", 32'(rs2_o), 32'(head.inst[7:5]));
        check("m_count", 32'(count_o), 32'(head.inst[7:5]));
        check("m_immed", 32'(immed_o), 32'(head.inst[7:0]));
        check("m_offset", 32'(offset_o), 32'(head.inst[7:0]));
        check("m_disp", 32'(disp_o), 32'(head.inst[7:0]));
        check("m_addr", 32'(addr_o), 32'(head.inst[11:0]));

        // Advance the model across the coming rising edge.
        if (flush_i) begin
            mq.delete();
            if (m_req && !ack_i) begin
                m_stale  = 1'b1;
                m_target = flush_addr_i;
            end else begin
                m_req   = 1'b1;
                m_stale = 1'b0;
                m_addr  = flush_addr_i;
            end
        end else if (m_req && ack_i && m_stale) begin
            m_stale = 1'b0;
            m_addr  = m_target;
        end else begin
            popped = exp_valid && ready_i;
            if (popped && !byp) void'(mq.pop_front());
            if (m_req && ack_i) begin
                if (!(byp && ready_i)) begin
                    e.inst = inst_i;
                    e.pc   = m_addr;
                    mq.push_back(e);
                end
                m_addr = m_addr + 1'b1;
                m_req  = (mq.size() < DEPTH);
            end else if (!m_req) begin
                m_req = (mq.size() < DEPTH);
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_ni) model_reset();
        else compare_and_step();
    end

    // One cycle of stimulus; memory only acks while a strobe is present.
    task automatic step(input bit ack_en, input bit rdy, input bit fl,
                        input logic [AW-1:0] fa, input logic [17:0] inst);
        @(posedge clk_i);
        #1;
        ack_i        = ack_en & fetch_stb_o;
        ready_i      = rdy;
        flush_i      = fl;
        flush_addr_i = fa;
        inst_i       = inst;
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, released just after a rising edge.
    task automatic do_reset();
        #1;
        rst_ni  = 1'b0;
        ack_i   = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("rst_stb", 32'(fetch_stb_o), 32'd0);
        check("rst_adr", 32'(fetch_adr_o), 32'(RESET_ADDR));
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_op", 32'(op_o), 32'd0);
        check("rst_immed", 32'(immed_o), 32'd0);
        rst_ni = 1'b1;
    endtask

    initial begin
        int adr_log[$];
        int acc;
        rst_ni       = 1'b0;
        ack_i        = 1'b0;
        ready_i      = 1'b0;
        flush_i      = 1'b0;
        flush_addr_i = '0;
        inst_i       = '0;

        // Streaming fetch with the consumer always ready.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 1'b0, '0, 18'(k * 7));
            if (fetch_stb_o) adr_log.push_back(int'(fetch_adr_o));
            if (k == 1) begin
                check("s1_valid_c1", 32'(valid_o), 32'd0);
            end else begin
                check("s1_valid", 32'(valid_o), 32'd1);
                check("s1_pc", 32'(pc_o), 32'(k - 2));
            end
        end
        check("s1_nadr", 32'(adr_log.size()), 32'd4);
        for (int i = 0; i < adr_log.size(); i++) check("s1_adr", 32'(adr_log[i]), 32'(i));

        // Stalled consumer fills the queue, then fetching resumes.
        do_reset();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b0, '0, 18'(k));
            if (ack_i) acc++;
        end
        check("s2_accepted", 32'(acc), 32'd2);
        check("s2_stb_low", 32'(fetch_stb_o), 32'd0);
        check("s2_head_pc", 32'(pc_o), 32'd0);
        step(1'b1, 1'b1, 1'b0, '0, 18'h0);
        step(1'b1, 1'b0, 1'b0, '0, 18'h0);
        check("s2_resume_stb", 32'(fetch_stb_o), 32'd1);
        check("s2_resume_adr", 32'(fetch_adr_o), 32'd2);
        check("s2_next_pc", 32'(pc_o), 32'd1);

        // Decode field extraction.
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0, 18'h29A5C);
        step(1'b0, 1'b0, 1'b0, '0, 18'h0);
        check("s3_valid", 32'(valid_o), 32'd1);
        check("s3_op", 32'(op_o), 32'h0A);
        check("s3_func", 32'(func_o), 32'h4);
        check("s3_rd", 32'(rd_o), 32'd3);
        check("s3_rs", 32'(rs_o), 32'd2);
        check("s3_rs2", 32'(rs2_o), 32'd2);
        check("s3_count", 32'(count_o), 32'd2);
        check("s3_immed", 32'(immed_o), 32'h5C);
        check("s3_offset", 32'(offset_o), 32'h5C);
        check("s3_disp", 32'(disp_o), 32'h5C);
        check("s3_addr", 32'(addr_o), 32'hA5C);

        // Flush while a request waits for its ack.
        do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 18'h0);
        step(1'b0, 1'b0, 1'b1, 12'h100, 18'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, '0, 18'h0);
            check("s4_wait_stb", 32'(fetch_stb_o), 32'd1);
            check("s4_wait_adr", 32'(fetch_adr_o), 32'd0);
            check("s4_wait_valid", 32'(valid_o), 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, '0, 18'h3FFFF);
        step(1'b1, 1'b0, 1'b0, '0, 18'h01234);
        check("s4_stale_valid", 32'(valid_o), 32'd0);
        check("s4_redir_adr", 32'(fetch_adr_o), 32'h100);
        step(1'b0, 1'b0, 1'b0, '0, 18'h0);
        check("s4_valid", 32'(valid_o), 32'd1);
        check("s4_pc", 32'(pc_o), 32'h100);
        check("s4_immed", 32'(immed_o), 32'h34);

        // Flush coinciding with an ack, then address wrap.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 12'hFFF, 18'h3FFFF);
        step(1'b1, 1'b0, 1'b0, '0, 18'h00011);
        check("s5_drop_valid", 32'(valid_o), 32'd0);
        check("s5_redir_adr", 32'(fetch_adr_o), 32'hFFF);
        step(1'b1, 1'b0, 1'b0, '0, 18'h00022);
        check("s5_wrap_adr", 32'(fetch_adr_o), 32'h000);
        check("s5_pc", 32'(pc_o), 32'hFFF);
        check("s5_immed", 32'(immed_o), 32'h11);

`ifdef IR_BYPASS_EN
        // Same-cycle forwarding into an empty queue.
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0, 18'h29A5C);
        check("s6_byp_valid", 32'(valid_o), 32'd1);
        check("s6_byp_op", 32'(op_o), 32'h0A);
        check("s6_byp_pc", 32'(pc_o), 32'd0);
        step(1'b0, 1'b0, 1'b0, '0, 18'h0);
        check("s6_empty", 32'(valid_o), 32'd0);
        check("s6_adr", 32'(fetch_adr_o), 32'd1);
`endif

        // Randomized traffic, including a reset in the middle of the run.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] fa;
            fa = ($urandom_range(0, 3) == 0) ? 12'hFFE : AW'($urandom);
            if (i == 1500) do_reset();
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 4, fa, 18'($urandom));
        end

        @(posedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
